// File: rtl/xnor_cmp_sched.sv
// ============================================================================
// Module      : xnor_cmp_sched
// Description : Two-requester bit-serial equality comparator built around a
//               single shared 1-bit XNOR gate, with round-robin arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xnor_cmp_sched #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_mask,
  output logic             rsp_eq,
  output logic             busy
);

  localparam int c_idx_w = $clog2(WIDTH);
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_mask;
  logic [c_idx_w-1:0] r_idx;
  logic               r_eq;
  logic               r_id;
  logic               r_prio1;

  logic w_grant0;
  logic w_grant1;
  logic w_idle;
  logic w_gate;

  // Requester 1 wins when alone, or when both ask and it is its turn.
  assign w_grant1 = req1_valid & (~req0_valid | r_prio1);
  assign w_grant0 = req0_valid & ~w_grant1;

  // rst_n is folded in so the readys drop the moment reset is applied.
  assign w_idle     = (r_state == S_IDLE) & rst_n;
  assign req0_ready = w_idle & w_grant0;
  assign req1_ready = w_idle & w_grant1;

  // The one shared comparison gate, walked LSB first over the captured operands.
  assign w_gate = r_a[r_idx] ~^ r_b[r_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_mask  <= '0;
      r_idx   <= '0;
      r_eq    <= 1'b0;
      r_id    <= 1'b0;
      r_prio1 <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant0 | w_grant1) begin
            r_a     <= w_grant1 ? req1_a : req0_a;
            r_b     <= w_grant1 ? req1_b : req0_b;
            r_id    <= w_grant1;
            r_prio1 <= ~w_grant1;
            r_idx   <= '0;
            r_mask  <= '0;
            r_eq    <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_mask[r_idx] <= w_gate;
          r_eq          <= r_eq & w_gate;
          if (r_idx == c_idx_last) begin
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign rsp_id    = r_id;
  assign rsp_mask  = r_mask;
  assign rsp_eq    = r_eq;

endmodule

`default_nettype wire

// File: tb/tb_xnor_cmp_sched.sv
// ============================================================================
// Module      : tb_xnor_cmp_sched
// Description : Self-checking bench: directed table, corner sequences and
//               randomized traffic against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xnor_cmp_sched;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid, rsp_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready, rsp_valid, rsp_id, rsp_eq, busy;
  logic [W-1:0] rsp_mask;

  xnor_cmp_sched #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_mask   (rsp_mask),
    .rsp_eq     (rsp_eq),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Transaction-level model: one job in flight at a time, round-robin grant,
  // response due WIDTH+1 cycles after the accept and held until consumed.
  bit           m_busy = 1'b0;
  bit           m_last = 1'b1;
  bit           m_id;
  logic [W-1:0] m_a, m_b;
  int           m_acc;

  always @(negedge clk) begin
    bit e0, e1;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_last = 1'b1;
      check("ready_in_reset", 32'({req0_ready, req1_ready}), 32'd0);
    end else begin
      e0 = 1'b0;
      e1 = 1'b0;
      if (!m_busy) begin
        if (req0_valid && req1_valid) begin
          e0 = m_last;
          e1 = !m_last;
        end else begin
          e0 = req0_valid;
          e1 = req1_valid;
        end
      end
      check("ready", 32'({req0_ready, req1_ready}), 32'({e0, e1}));
      check("busy", 32'(busy), 32'(m_busy));
      check("rsp_valid", 32'(rsp_valid), 32'(m_busy && (cyc - m_acc >= W + 1)));
      if (rsp_valid && m_busy)
        check("rsp_fields", 32'({rsp_id, rsp_eq, rsp_mask}),
              32'({m_id, m_a == m_b, ~(m_a ^ m_b)}));
      if (rsp_valid && rsp_ready) begin
        m_busy = 1'b0;
      end else if (e0 || e1) begin
        m_busy = 1'b1;
        m_id   = e1;
        m_last = e1;
        m_a    = e1 ? req1_a : req0_a;
        m_b    = e1 ? req1_b : req0_b;
        m_acc  = cyc;
      end
    end
  end

  task automatic wait_idle();
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!busy) return;
    end
    check("idle_timeout", 32'd1, 32'd0);
  endtask

  // Launch one job on a single requester, scramble its inputs after capture,
  // and collect the response as seen at the first rsp_valid cycle.
  task automatic run_job(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output logic [W-1:0] mask,
                         output logic eq, output logic rid);
    bit got;
    int acc;
    lat = -1; mask = '0; eq = 1'b0; rid = 1'b0;
    @(posedge clk); #2;
    if (id) begin req1_valid = 1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1; req0_a = a; req0_b = b; end
    got = 0;
    acc = 0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin got = 1; acc = cyc; end
    end
    if (!got) begin check("accept_timeout", 32'd1, 32'd0); return; end
    @(posedge clk); #2;
    req0_valid = 0; req1_valid = 0;
    req0_a = W'($urandom); req0_b = W'($urandom);
    req1_a = W'($urandom); req1_b = W'($urandom);
    got = 0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1; lat = cyc - acc; mask = rsp_mask; eq = rsp_eq; rid = rsp_id;
      end
    end
    if (!got) check("rsp_timeout", 32'd1, 32'd0);
  endtask

  typedef struct {
    bit           id;
    logic [W-1:0] a, b, mask;
    logic         eq;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int           lat;
    logic [W-1:0] mask, mask_hold;
    logic         eq, rid;
    int           ids[$];

    vecs[0] = '{id: 1'b0, a: 8'hA5, b: 8'hA5, mask: 8'hFF, eq: 1'b1};
    vecs[1] = '{id: 1'b1, a: 8'h0F, b: 8'h0E, mask: 8'hFE, eq: 1'b0};
    vecs[2] = '{id: 1'b0, a: 8'h00, b: 8'hFF, mask: 8'h00, eq: 1'b0};
    vecs[3] = '{id: 1'b1, a: 8'hFF, b: 8'hFF, mask: 8'hFF, eq: 1'b1};
    vecs[4] = '{id: 1'b0, a: 8'h80, b: 8'h00, mask: 8'h7F, eq: 1'b0};
    vecs[5] = '{id: 1'b1, a: 8'h3C, b: 8'hC3, mask: 8'h00, eq: 1'b0};

    rst_n = 0; req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    #3;
    check("reset_state", 32'({busy, rsp_valid, rsp_id, rsp_eq, rsp_mask}), 32'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1;

    // Contention from power-up: grants must alternate starting with requester 0.
    @(posedge clk); #2;
    req0_valid = 1; req1_valid = 1;
    req0_a = 8'h11; req0_b = 8'h12; req1_a = 8'h77; req1_b = 8'h77;
    for (int k = 0; k < 100 && ids.size() < 4; k++) begin
      @(negedge clk);
      if (req0_ready) ids.push_back(0);
      if (req1_ready) ids.push_back(1);
    end
    @(posedge clk); #2;
    req0_valid = 0; req1_valid = 0;
    check("contention_count", 32'(ids.size()), 32'd4);
    for (int i = 0; i < ids.size() && i < 4; i++)
      check("contention_id", 32'(ids[i]), 32'(i % 2));
    wait_idle();

    for (int i = 0; i < 6; i++) begin
      run_job(vecs[i].id, vecs[i].a, vecs[i].b, lat, mask, eq, rid);
      check("vec_latency", 32'(lat), 32'(W + 1));
      check("vec_id", 32'(rid), 32'(vecs[i].id));
      check("vec_mask", 32'(mask), 32'(vecs[i].mask));
      check("vec_eq", 32'(eq), 32'(vecs[i].eq));
      wait_idle();
    end

    // Back-pressure: hold DONE for 5 cycles with both requesters waiting.
    rsp_ready = 0;
    run_job(1'b0, 8'h5A, 8'h5B, lat, mask_hold, eq, rid);
    check("bp_mask", 32'(mask_hold), 32'h0000_00FE);
    @(posedge clk); #2;
    req0_valid = 1; req1_valid = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold", 32'({rsp_valid, rsp_mask, req0_ready, req1_ready}),
            32'({1'b1, 8'hFE, 2'b00}));
    end
    @(posedge clk); #2 rsp_ready = 1;
    @(negedge clk);
    check("bp_release_valid", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    check("bp_next_accept", 32'({req0_ready, req1_ready}), 32'b01);
    @(posedge clk); #2;
    req0_valid = 0; req1_valid = 0;
    wait_idle();
    wait_idle();

    // Reset in the middle of SHIFT, at bit index 4.
    @(posedge clk); #2;
    req0_valid = 1; req0_a = 8'h33; req0_b = 8'h33;
    for (int k = 0; k < 30 && !req0_ready; k++) @(negedge clk);
    @(posedge clk); #2 req0_valid = 0;
    repeat (4) @(posedge clk);
    #3 rst_n = 0;
    #1;
    check("async_reset", 32'({busy, rsp_valid, rsp_id, rsp_eq, rsp_mask, req0_ready, req1_ready}), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rsp_valid) check("stale_rsp", 32'd1, 32'd0);
    end
    run_job(1'b0, 8'h00, 8'hFF, lat, mask, eq, rid);
    check("post_reset_job", 32'({lat[7:0], rid, eq, mask}), 32'({8'(W + 1), 1'b0, 1'b0, 8'h00}));
    wait_idle();

    // Random traffic; the model checks every cycle.
    for (int k = 0; k < 500; k++) begin
      @(posedge clk); #2;
      req0_valid = ($urandom_range(0, 1) == 1);
      req1_valid = ($urandom_range(0, 1) == 1);
      rsp_ready  = ($urandom_range(0, 3) != 0);
      req0_a = W'($urandom); req0_b = ($urandom_range(0, 3) == 0) ? req0_a : W'($urandom);
      req1_a = W'($urandom); req1_b = ($urandom_range(0, 3) == 0) ? req1_a : W'($urandom);
    end
    @(posedge clk); #2;
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    wait_idle();
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/xnor_cmp_sched.md
XNOR_CMP_SCHED -- requirements
Module: xnor_cmp_sched

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has a compare job pending.
REQ-005 req0_ready  output  1  requester 0 job accepted this cycle when valid also high.
REQ-006 req0_a, req0_b  input  WIDTH each  requester 0 operands.
REQ-007 req1_valid, req1_ready, req1_a, req1_b  same as REQ-004..006, for requester 1.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  consumer accepts result.
REQ-010 rsp_id  output  1  requester index that owns the result.
REQ-011 rsp_mask  output  WIDTH  bitwise XNOR of the job operands.
REQ-012 rsp_eq  output  1  1 when the operands are equal, i.e. all rsp_mask bits are 1.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 Block SHALL contain exactly one 1-bit XNOR gate instance, shared by both requesters and used once per cycle; no other XNOR/XOR logic on operand data.
REQ-015 FSM states SHALL be: IDLE, SHIFT, DONE.
REQ-016 In IDLE, at most one reqN_ready SHALL be high, and only for the granted requester; both readys SHALL be low in SHIFT and DONE.
REQ-017 Grant, only one requester valid -> grant that requester.
REQ-018 Grant, both valid -> grant the requester not granted last (round-robin); first arbitration after reset favours requester 0.
REQ-019 Grant pointer SHALL update only on an accept handshake (valid and ready both high).
REQ-020 Accept handshake in IDLE -> capture a, b, and id; clear index to 0; set mask to 0 and eq accumulator to 1; next state SHIFT.
REQ-021 SHIFT, each cycle: gate inputs = a[idx], b[idx] (LSB first); mask[idx] <= gate out; eq <= eq AND gate out; idx <= idx+1.
REQ-022 SHIFT with idx == WIDTH-1 -> next state DONE; idx SHALL NOT wrap inside SHIFT.
REQ-023 rsp_valid SHALL be high exactly in DONE; rsp_id/rsp_mask/rsp_eq SHALL be stable while rsp_valid is high.
REQ-024 Latency: rsp_valid SHALL rise WIDTH+1 clock edges after the accept edge (WIDTH SHIFT cycles, then DONE).
REQ-025 DONE with rsp_ready high -> IDLE on the next edge; with rsp_ready low, hold DONE indefinitely (back-pressure).
REQ-026 Re-arbitration SHALL occur in the first IDLE cycle after DONE; minimum job-to-job spacing is WIDTH+2 cycles.
REQ-027 Operand changes on reqN_a/b after accept SHALL NOT affect the job in flight.
REQ-028 reqN_valid dropped after accept SHALL NOT affect the job in flight.
REQ-029 Index counter width SHALL be ceil(log2(WIDTH)) bits; no arithmetic overflow is permitted.

Reset
REQ-030 rst_n low SHALL force, immediately and without clk: state IDLE, busy 0, rsp_valid 0, rsp_id 0, rsp_mask 0, rsp_eq 0, idx 0, grant pointer favouring requester 0.
REQ-031 Reset asserted mid-SHIFT or in DONE SHALL discard the job with no response; the first job after deassertion SHALL behave as after power-up.
REQ-032 reqN_ready SHALL be low while rst_n is low.

Verification (WIDTH=8)
REQ-033 Single job: req0 a=0xA5, b=0xA5 -> 9 edges after accept, rsp_valid=1, id=0, mask=0xFF, eq=1.
REQ-034 Mismatch: req1 a=0x0F, b=0x0E -> mask=0xFE, eq=0, id=1.
REQ-035 Contention: both valid continuously, 4 jobs -> accepted ids 0,1,0,1; every response arrives with latency 9.
REQ-036 Back-pressure: rsp_ready held low 5 cycles in DONE -> rsp_valid and outputs stable, both readys low; the next accept occurs in the first IDLE cycle after rsp_ready rises.
REQ-037 Reset mid-op: rst_n low at SHIFT idx=4 -> all outputs at reset values asynchronously; no stale rsp_valid after release; the next req0 job a=0x00, b=0xFF yields mask=0x00, eq=0.
REQ-038 Operand change: after accept, drive req0_a to a new value -> result reflects the captured operands only.
